// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fronted by a byte FIFO; queued frames are sent back to back.
// Line, active and done outputs are registered from the FSM state.
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_W       = 4
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Tx_DV,
    input  logic [7:0]        i_Tx_Byte,
    output logic              o_Tx_Ready,
    output logic              o_Tx_Overflow,
    output logic [ADDR_W:0]   o_Fifo_Count,
    output logic              o_Tx_Serial,
    output logic              o_Tx_Active,
    output logic              o_Tx_Done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } state_t;

    localparam logic [15:0]   LAST_CLK = 16'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0] DEPTH  = (ADDR_W + 1)'(FIFO_DEPTH);

    state_t            state, state_next;
    logic [15:0]       clk_cnt, clk_cnt_next;
    logic [2:0]        bit_idx, bit_idx_next;
    logic [7:0]        shift;
    logic              serial_next, active_next, done_next;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count, count_next;
    logic              push, pop;

    assign push = i_Tx_DV & o_Tx_Ready;
    assign pop  = (state == IDLE) && (count != '0);
    assign o_Fifo_Count = count;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Storage is left unreset; only the pointers and count define contents.
    always_ff @(posedge i_Clock) begin
        if (push) mem[wr_ptr] <= i_Tx_Byte;
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            o_Tx_Ready    <= 1'b1;
            o_Tx_Overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count         <= count_next;
            o_Tx_Ready    <= (count_next < DEPTH);
            o_Tx_Overflow <= i_Tx_DV & ~o_Tx_Ready;
        end
    end

    always_comb begin
        state_next   = state;
        clk_cnt_next = clk_cnt;
        bit_idx_next = bit_idx;
        serial_next  = 1'b1;
        active_next  = 1'b0;
        done_next    = 1'b0;
        case (state)
            IDLE: begin
                clk_cnt_next = '0;
                if (pop) state_next = START;
            end
            START: begin
                serial_next = 1'b0;
                active_next = 1'b1;
                if (clk_cnt == LAST_CLK) begin
                    clk_cnt_next = '0;
                    bit_idx_next = '0;
                    state_next   = DATA;
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
            DATA: begin
                serial_next = shift[bit_idx];
                active_next = 1'b1;
                if (clk_cnt == LAST_CLK) begin
                    clk_cnt_next = '0;
                    if (bit_idx == 3'd7) state_next = STOP;
                    else                 bit_idx_next = bit_idx + 1'b1;
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
            STOP: begin
                active_next = 1'b1;
                if (clk_cnt == LAST_CLK) begin
                    clk_cnt_next = '0;
                    state_next   = CLEANUP;
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
            CLEANUP: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
        end else begin
            state       <= state_next;
            clk_cnt     <= clk_cnt_next;
            bit_idx     <= bit_idx_next;
            if (pop) shift <= mem[rd_ptr];
            o_Tx_Serial <= serial_next;
            o_Tx_Active <= active_next;
            o_Tx_Done   <= done_next;
        end
    end

endmodule
